// File: rtl/bullet_arbiter.sv
// bullet_arbiter: round-robin fire arbitration into a bullet slot pool,
// per-frame bullet motion and pixel hit. Option: BULLET_COOLDOWN_EN.
module bullet_arbiter #(
  parameter int         NUM_SLOTS   = 4,
  parameter logic [9:0] SPEED       = 10'd4,
  parameter logic [9:0] TANK_SIZE   = 10'd50,
  parameter logic [9:0] BULLET_SIZE = 10'd4,
  parameter logic [9:0] X_MAX       = 10'd639,
  parameter logic [9:0] Y_MAX       = 10'd479,
  parameter logic [3:0] COOLDOWN    = 4'd8
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_clk,
  input  logic [1:0]                fire_req,
  input  logic [9:0]                tank0_X,
  input  logic [9:0]                tank0_Y,
  input  logic [9:0]                tank1_X,
  input  logic [9:0]                tank1_Y,
  input  logic [1:0]                tank0_dir,
  input  logic [1:0]                tank1_dir,
  input  logic [9:0]                DrawX,
  input  logic [9:0]                DrawY,
  output logic [NUM_SLOTS-1:0]      bullet_active,
  output logic [NUM_SLOTS-1:0]      bullet_owner,
  output logic [10*NUM_SLOTS-1:0]   bullet_X,
  output logic [10*NUM_SLOTS-1:0]   bullet_Y,
  output logic [1:0]                fire_grant,
  output logic                      busy,
  output logic                      is_bullet
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [9:0]  HALF = TANK_SIZE >> 1;
  localparam logic [10:0] STEP_SZ = {1'b0, SPEED} + {1'b0, BULLET_SIZE};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_ALLOC1,
    S_ALLOC2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0] r_fire_q;
  logic [1:0] r_fire_rise;
  logic       r_frame_q;
  logic       r_tick;
  logic [1:0] r_pending;
  logic       r_rr;

  logic [NUM_SLOTS-1:0]       r_active;
  logic [NUM_SLOTS-1:0]       r_owner;
  logic [NUM_SLOTS-1:0][1:0]  r_dir;
  logic [NUM_SLOTS-1:0][9:0]  r_x;
  logic [NUM_SLOTS-1:0][9:0]  r_y;

  logic          w_alloc;
  logic          w_sel_valid;
  logic          w_sel_tank;
  logic          w_free_valid;
  logic [IW-1:0] w_free_idx;
  logic          w_do_grant;
  logic [1:0]    w_grant;
  logic [1:0]    w_cool_zero;
  logic [9:0]    w_spawn_x;
  logic [9:0]    w_spawn_y;
  logic [1:0]    w_spawn_dir;

  // Registered edge detectors for the frame strobe and fire levels
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_frame_q   <= 1'b0;
      r_tick      <= 1'b0;
      r_fire_q    <= 2'b00;
      r_fire_rise <= 2'b00;
    end else begin
      r_frame_q   <= frame_clk;
      r_tick      <= frame_clk & ~r_frame_q;
      r_fire_q    <= fire_req;
      r_fire_rise <= fire_req & ~r_fire_q;
    end
  end

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state: one frame walks MOVE, ALLOC1, ALLOC2
  always_comb begin
    w_next  = r_state;
    busy    = 1'b1;
    w_alloc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (r_tick) w_next = S_MOVE;
      end
      S_MOVE:   w_next = S_ALLOC1;
      S_ALLOC1: begin
        w_alloc = 1'b1;
        w_next  = S_ALLOC2;
      end
      S_ALLOC2: begin
        w_alloc = 1'b1;
        w_next  = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Pick the tank (rr first) and the lowest free slot
  always_comb begin
    w_sel_valid  = |r_pending;
    w_sel_tank   = r_pending[r_rr] ? r_rr : ~r_rr;
    w_free_valid = ~&r_active;
    w_free_idx   = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!r_active[k]) w_free_idx = IW'(k);
    end
    w_do_grant = w_alloc & w_sel_valid & w_free_valid;
    w_grant    = 2'b00;
    if (w_do_grant) w_grant[w_sel_tank] = 1'b1;
    w_spawn_x   = w_sel_tank ? (tank1_X + HALF) : (tank0_X + HALF);
    w_spawn_y   = w_sel_tank ? (tank1_Y + HALF) : (tank0_Y + HALF);
    w_spawn_dir = w_sel_tank ? tank1_dir : tank0_dir;
  end

  assign fire_grant = w_grant;

  // Pending requests and round-robin pointer
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pending <= 2'b00;
      r_rr      <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_grant[i])
          r_pending[i] <= 1'b0;
        else if (r_fire_rise[i] && w_cool_zero[i])
          r_pending[i] <= 1'b1;
      end
      if (w_do_grant) r_rr <= ~w_sel_tank;
    end
  end

`ifdef BULLET_COOLDOWN_EN
  logic [1:0][3:0] r_cool;

  // Per-tank refire block: loaded on grant, counts frames down
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cool <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_grant[i])
          r_cool[i] <= COOLDOWN;
        else if (r_state == S_MOVE && r_cool[i] != 4'd0)
          r_cool[i] <= r_cool[i] - 4'd1;
      end
    end
  end

  assign w_cool_zero = {r_cool[1] == 4'd0, r_cool[0] == 4'd0};
`else
  logic w_unused_cd;
  assign w_unused_cd = ^COOLDOWN;
  assign w_cool_zero = 2'b11;
`endif

  // Slot pool: step or retire in MOVE, spawn on grant
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_active <= '0;
      r_owner  <= '0;
      r_dir    <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (r_state == S_MOVE) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (r_active[k]) begin
          unique case (r_dir[k])
            2'b00: begin
              if (r_y[k] < SPEED) r_active[k] <= 1'b0;
              else                r_y[k] <= r_y[k] - SPEED;
            end
            2'b01: begin
              if (({1'b0, r_y[k]} + STEP_SZ) > {1'b0, Y_MAX})
                r_active[k] <= 1'b0;
              else
                r_y[k] <= r_y[k] + SPEED;
            end
            2'b10: begin
              if (r_x[k] < SPEED) r_active[k] <= 1'b0;
              else                r_x[k] <= r_x[k] - SPEED;
            end
            default: begin
              if (({1'b0, r_x[k]} + STEP_SZ) > {1'b0, X_MAX})
                r_active[k] <= 1'b0;
              else
                r_x[k] <= r_x[k] + SPEED;
            end
          endcase
        end
      end
    end else if (w_do_grant) begin
      r_active[w_free_idx] <= 1'b1;
      r_owner[w_free_idx]  <= w_sel_tank;
      r_dir[w_free_idx]    <= w_spawn_dir;
      r_x[w_free_idx]      <= w_spawn_x;
      r_y[w_free_idx]      <= w_spawn_y;
    end
  end

  // Pixel hit against every live bullet square, 11-bit so no wrap
  always_comb begin
    is_bullet = 1'b0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (r_active[k] &&
          ({1'b0, DrawX} >= {1'b0, r_x[k]}) &&
          ({1'b0, DrawX} <  ({1'b0, r_x[k]} + {1'b0, BULLET_SIZE})) &&
          ({1'b0, DrawY} >= {1'b0, r_y[k]}) &&
          ({1'b0, DrawY} <  ({1'b0, r_y[k]} + {1'b0, BULLET_SIZE})))
        is_bullet = 1'b1;
    end
  end

  assign bullet_active = r_active;
  assign bullet_owner  = r_owner;
  assign bullet_X      = r_x;
  assign bullet_Y      = r_y;

endmodule

// File: tb/tb_bullet_arbiter.sv
// tb_bullet_arbiter: directed checks of arbitration, slot motion,
// boundary clearing, pixel hit and reset behaviour of bullet_arbiter.
module tb_bullet_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [1:0]  fire_req = 2'b00;
  logic [9:0]  tank0_X = '0, tank0_Y = '0, tank1_X = '0, tank1_Y = '0;
  logic [1:0]  tank0_dir = '0, tank1_dir = '0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic [3:0]  bullet_active, bullet_owner;
  logic [39:0] bullet_X, bullet_Y;
  logic [1:0]  fire_grant;
  logic        busy, is_bullet;

  int n_assert = 0;
  int n_fail = 0;
  logic [1:0] g_a1, g_a2, g_mv;
  int busy_cnt, first_busy;

  bullet_arbiter dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire_req(fire_req),
    .tank0_X(tank0_X), .tank0_Y(tank0_Y),
    .tank1_X(tank1_X), .tank1_Y(tank1_Y),
    .tank0_dir(tank0_dir), .tank1_dir(tank1_dir),
    .DrawX(DrawX), .DrawY(DrawY),
    .bullet_active(bullet_active), .bullet_owner(bullet_owner),
    .bullet_X(bullet_X), .bullet_Y(bullet_Y),
    .fire_grant(fire_grant), .busy(busy), .is_bullet(is_bullet)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    fire_req = 2'b00;
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic fire(input logic [1:0] m);
    @(negedge Clk);
    fire_req = m;
    repeat (3) @(negedge Clk);
    fire_req = 2'b00;
    @(negedge Clk);
  endtask

  task automatic run_frame();
    int nb;
    nb = 0;
    first_busy = -1;
    g_a1 = 2'b00;
    g_a2 = 2'b00;
    g_mv = 2'b00;
    @(negedge Clk);
    frame_clk = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (c == 0) frame_clk = 1'b0;
      if (busy) begin
        nb++;
        if (first_busy < 0) first_busy = c;
        if (nb == 1) g_mv = fire_grant;
        if (nb == 2) g_a1 = fire_grant;
        if (nb == 3) g_a2 = fire_grant;
      end
    end
    busy_cnt = nb;
  endtask

  function automatic logic [9:0] sx(input int k);
    return bullet_X[10*k +: 10];
  endfunction

  function automatic logic [9:0] sy(input int k);
    return bullet_Y[10*k +: 10];
  endfunction

  initial begin
    // Reset held with a fire level present
    fire_req = 2'b01;
    repeat (3) @(negedge Clk);
    chk("rst_active", bullet_active, 4'b0000);
    chk("rst_owner", bullet_owner, 4'b0000);
    chk("rst_x", bullet_X, 40'd0);
    chk("rst_y", bullet_Y, 40'd0);
    chk("rst_grant", fire_grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hit", is_bullet, 1'b0);
    Reset = 1'b0;
    fire_req = 2'b00;
    @(negedge Clk);
    run_frame();
    chk("rst_frame_a1", g_a1, 2'b00);
    chk("rst_frame_active", bullet_active, 4'b0000);

    // Single shot from tank0 facing right
    tank0_X = 10'd100; tank0_Y = 10'd200; tank0_dir = 2'b11;
    fire(2'b01);
    run_frame();
    chk("t0_first_busy", first_busy, 1);
    chk("t0_busy_cnt", busy_cnt, 3);
    chk("t0_move_grant", g_mv, 2'b00);
    chk("t0_a1", g_a1, 2'b01);
    chk("t0_a2", g_a2, 2'b00);
    chk("t0_active", bullet_active, 4'b0001);
    chk("t0_owner", bullet_owner, 4'b0000);
    chk("t0_x0", sx(0), 10'd125);
    chk("t0_y0", sy(0), 10'd225);
    run_frame();
    chk("t0_step_x0", sx(0), 10'd129);
    chk("t0_step_y0", sy(0), 10'd225);
    chk("t0_step_a1", g_a1, 2'b00);

    // Refire three frames after the grant
    run_frame();
    run_frame();
    fire(2'b01);
    run_frame();
`ifdef BULLET_COOLDOWN_EN
    chk("cd_early_a1", g_a1, 2'b00);
    chk("cd_early_active", bullet_active, 4'b0001);
    repeat (4) run_frame();
    fire(2'b01);
    run_frame();
    chk("cd_late_a1", g_a1, 2'b01);
    chk("cd_late_active", bullet_active, 4'b0011);
`else
    chk("nocd_a1", g_a1, 2'b01);
    chk("nocd_active", bullet_active, 4'b0011);
    chk("nocd_x1", sx(1), 10'd125);
    chk("nocd_x0", sx(0), 10'd141);
`endif

    // Dual request, rr=0 after reset
    do_reset();
    tank0_X = 10'd100; tank0_Y = 10'd200; tank0_dir = 2'b11;
    tank1_X = 10'd300; tank1_Y = 10'd100; tank1_dir = 2'b10;
    fire(2'b11);
    run_frame();
    chk("dual_a1", g_a1, 2'b01);
    chk("dual_a2", g_a2, 2'b10);
    chk("dual_active", bullet_active, 4'b0011);
    chk("dual_owner", bullet_owner, 4'b0010);
    chk("dual_x1", sx(1), 10'd325);
    chk("dual_y1", sy(1), 10'd125);
    fire(2'b01);
    run_frame();
    chk("solo_a1", g_a1, 2'b01);
    chk("solo_active", bullet_active, 4'b0111);
    fire(2'b11);
    run_frame();
    chk("rr_a1", g_a1, 2'b10);
    chk("full_a2", g_a2, 2'b00);
    chk("rr_active", bullet_active, 4'b1111);
    chk("rr_owner", bullet_owner, 4'b1010);
    chk("rr_x3", sx(3), 10'd325);
    chk("rr_x1", sx(1), 10'd317);
    run_frame();
    chk("full_retry_a1", g_a1, 2'b00);
    chk("full_retry_a2", g_a2, 2'b00);

`ifndef BULLET_COOLDOWN_EN
    // Pool full, slot0 retires off the left edge
    do_reset();
    tank1_X = 10'd0; tank1_Y = 10'd100; tank1_dir = 2'b10;
    tank0_X = 10'd100; tank0_Y = 10'd200; tank0_dir = 2'b00;
    fire(2'b10);
    run_frame();
    chk("left_a1", g_a1, 2'b10);
    chk("left_x0", sx(0), 10'd25);
    repeat (3) begin
      fire(2'b01);
      run_frame();
    end
    chk("fill_active", bullet_active, 4'b1111);
    fire(2'b10);
    repeat (3) run_frame();
    chk("wait_a1", g_a1, 2'b00);
    chk("wait_x0", sx(0), 10'd1);
    chk("wait_active", bullet_active, 4'b1111);
    run_frame();
    chk("freed_a1", g_a1, 2'b10);
    chk("freed_x0", sx(0), 10'd25);
    chk("freed_owner", bullet_owner, 4'b0001);
    chk("freed_active", bullet_active, 4'b1111);
`endif

    // Bullet at the right edge and pixel hit window
    do_reset();
    tank0_X = 10'd611; tank0_Y = 10'd75; tank0_dir = 2'b11;
    fire(2'b01);
    run_frame();
    chk("edge_x0", sx(0), 10'd636);
    chk("edge_y0", sy(0), 10'd100);
    DrawX = 10'd636; DrawY = 10'd100; #1;
    chk("hit_tl", is_bullet, 1'b1);
    DrawX = 10'd639; DrawY = 10'd103; #1;
    chk("hit_br", is_bullet, 1'b1);
    DrawX = 10'd640; DrawY = 10'd100; #1;
    chk("hit_xout", is_bullet, 1'b0);
    DrawX = 10'd635; DrawY = 10'd100; #1;
    chk("hit_xlow", is_bullet, 1'b0);
    DrawX = 10'd636; DrawY = 10'd104; #1;
    chk("hit_yout", is_bullet, 1'b0);
    DrawX = 10'd636; DrawY = 10'd99; #1;
    chk("hit_ylow", is_bullet, 1'b0);
    run_frame();
    chk("edge_cleared", bullet_active, 4'b0000);
    DrawX = 10'd636; DrawY = 10'd100; #1;
    chk("hit_after", is_bullet, 1'b0);

    // Reset in the middle of a frame sequence
    tank0_X = 10'd100; tank0_Y = 10'd200;
    fire(2'b01);
    @(negedge Clk);
    frame_clk = 1'b1;
    begin
      int w;
      w = 0;
      while (!busy && w < 6) begin
        @(negedge Clk);
        w++;
      end
      chk("mid_reach_busy", busy, 1'b1);
    end
    Reset = 1'b1;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_grant", fire_grant, 2'b00);
    chk("mid_active", bullet_active, 4'b0000);
    @(negedge Clk);
    Reset = 1'b0;
    frame_clk = 1'b0;
    @(negedge Clk);
    run_frame();
    chk("mid_after_a1", g_a1, 2'b00);
    chk("mid_after_active", bullet_active, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
